md_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage beside the ALU and is driven by the decoder's md_op/start/hi/lo control group.
- Adds configurable width, independent multiply and divide latencies, and multiply-accumulate modes: madd, maddu, msub, msubu.
- Exposes busy so the hazard unit can stall dependent mult/div/mfhi/mflo/mthi/mtlo instructions.

---
 rtl/md_pkg.sv | 31 +++
 rtl/md_unit_if.sv | 36 +++
 rtl/md_arith.sv | 66 ++++++
 rtl/md_unit.sv | 106 ++++++++++
 tb/tb_md_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg : opcodes, FSM encoding and helpers shared by the multiply/divide unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package md_pkg;

   typedef logic [2:0] md_op_t;

   localparam md_op_t MD_OP_MULT  = 3'b000;
   localparam md_op_t MD_OP_MULTU = 3'b001;
   localparam md_op_t MD_OP_DIV   = 3'b010;
   localparam md_op_t MD_OP_DIVU  = 3'b011;
   localparam md_op_t MD_OP_MADD  = 3'b100;
   localparam md_op_t MD_OP_MADDU = 3'b101;
   localparam md_op_t MD_OP_MSUB  = 3'b110;
   localparam md_op_t MD_OP_MSUBU = 3'b111;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic is_div(input md_op_t op);
      return (op[2:1] == 2'b01);
   endfunction

endpackage

`default_nettype wire

// File: rtl/md_unit_if.sv
// ---------------------------------------------------------------------------
// md_unit_if : decoder-side control/data group and HI/LO read-back of md_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface md_unit_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic [2:0]       md_op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wd;
   logic             rd_sel;
   logic             busy;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, md_op, a, b, hi_we, lo_we, wd, rd_sel,
      input  busy, rd_data, hi, lo
   );

   modport slave (
      input  start, md_op, a, b, hi_we, lo_we, wd, rd_sel,
      output busy, rd_data, hi, lo
   );

endinterface

`default_nettype wire

// File: rtl/md_arith.sv
// ---------------------------------------------------------------------------
// md_arith : combinational multiply / accumulate / divide datapath
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module md_arith
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  wire md_op_t           op,
   input  wire logic [WIDTH-1:0] a,
   input  wire logic [WIDTH-1:0] b,
   input  wire logic [2*WIDTH-1:0] acc,
   output logic [2*WIDTH-1:0]    result,
   output logic                  div_by_zero
);

   localparam int W2 = 2 * WIDTH;
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [W2-1:0]    sprod;
   logic [W2-1:0]           uprod;
   logic signed [WIDTH-1:0] sq;
   logic signed [WIDTH-1:0] sr;
   logic [WIDTH-1:0]        uq;
   logic [WIDTH-1:0]        ur;

   always_comb begin
      sprod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      sq    = '0;
      sr    = '0;
      uq    = '0;
      ur    = '0;
      div_by_zero = is_div(op) && (b == '0);

      // MIN_INT / -1 overflows the quotient; pin it to the architectural result
      if (b != '0) begin
         uq = a / b;
         ur = a % b;
         if ((a == MIN_INT) && (b == {WIDTH{1'b1}})) begin
            sq = $signed(MIN_INT);
            sr = '0;
         end else begin
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
         end
      end

      case (op)
         MD_OP_MULT:  result = sprod;
         MD_OP_MULTU: result = uprod;
         MD_OP_DIV:   result = {sr, sq};
         MD_OP_DIVU:  result = {ur, uq};
         MD_OP_MADD:  result = acc + sprod;
         MD_OP_MADDU: result = acc + uprod;
         MD_OP_MSUB:  result = acc - sprod;
         default:     result = acc - uprod;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit : multi-cycle multiply/divide unit with HI/LO registers and busy stall
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input wire logic clk,
   input wire logic reset,
   md_unit_if.slave bus
);

   localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_nxt;
   logic [2*WIDTH-1:0]   staged;
   logic [2*WIDTH-1:0]   staged_nxt;
   logic                 skip;
   logic                 skip_nxt;
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     hi_nxt;
   logic [WIDTH-1:0]     lo_q;
   logic [WIDTH-1:0]     lo_nxt;
   logic [2*WIDTH-1:0]   arith_res;
   logic                 arith_dbz;

   md_arith #(
      .WIDTH (WIDTH)
   ) u_arith (
      .op          (bus.md_op),
      .a           (bus.a),
      .b           (bus.b),
      .acc         ({hi_q, lo_q}),
      .result      (arith_res),
      .div_by_zero (arith_dbz)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         staged <= '0;
         skip   <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         staged <= staged_nxt;
         skip   <= skip_nxt;
         hi_q   <= hi_nxt;
         lo_q   <= lo_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      staged_nxt = staged;
      skip_nxt   = skip;
      hi_nxt     = hi_q;
      lo_nxt     = lo_q;

      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               staged_nxt = arith_res;
               skip_nxt   = arith_dbz;
               cnt_nxt    = is_div(bus.md_op) ? DIV_LOAD : MUL_LOAD;
               state_nxt  = ST_BUSY;
            end else begin
               if (bus.hi_we) hi_nxt = bus.wd;
               if (bus.lo_we) lo_nxt = bus.wd;
            end
         end
         default: begin
            cnt_nxt = cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
               state_nxt = ST_IDLE;
               // divide by zero leaves HI/LO untouched
               if (!skip) {hi_nxt, lo_nxt} = staged;
            end
         end
      endcase
   end

   assign bus.busy    = (state == ST_BUSY);
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit : directed and randomized checks of md_unit against a 64-bit model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_md_unit;
   import md_pkg::*;

   localparam int MUL = 5;
   localparam int DIV = 10;

   logic clk = 1'b0;
   logic reset;

   md_unit_if #(.WIDTH(32)) bus ();

   md_unit #(
      .WIDTH      (32),
      .MUL_CYCLES (MUL),
      .DIV_CYCLES (DIV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: returns {div_by_zero, new {HI,LO}} from plain integer arithmetic.
   function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
      longint    sa, sb, sp;
      logic [63:0] up;
      int        qa, qb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sp = sa * sb;
      up = {32'd0, a} * {32'd0, b};
      case (op)
         3'd0: return {1'b0, 64'(sp)};
         3'd1: return {1'b0, up};
         3'd4: return {1'b0, acc + 64'(sp)};
         3'd5: return {1'b0, acc + up};
         3'd6: return {1'b0, acc - 64'(sp)};
         3'd7: return {1'b0, acc - up};
         3'd2: begin
            if (b == 0) return {1'b1, acc};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
            qa = $signed(a);
            qb = $signed(b);
            q  = qa / qb;
            r  = qa % qb;
            return {1'b0, 32'(r), 32'(q)};
         end
         default: begin
            if (b == 0) return {1'b1, acc};
            return {1'b0, a % b, a / b};
         end
      endcase
   endfunction

   // Caller is #1 after a posedge. inject: re-start and mthi mid-operation.
   // with_we: assert hi_we/lo_we in the same cycle as start.
   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject, input bit with_we);
      logic [64:0] exp;
      logic [31:0] pre_hi;
      int          n;
      int          lat;
      exp    = model(op, a, b, {m_hi, m_lo});
      lat    = is_div(op) ? DIV : MUL;
      pre_hi = m_hi;
      bus.start  = 1'b1;
      bus.md_op  = op;
      bus.a      = a;
      bus.b      = b;
      bus.rd_sel = 1'b1;
      if (with_we) begin
         bus.hi_we = 1'b1;
         bus.lo_we = 1'b1;
         bus.wd    = 32'hCAFE_F00D;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      n = 0;
      while (bus.busy && n < 200) begin
         n++;
         if (n == 1) check({tag, "_rd_busy"}, bus.rd_data, pre_hi);
         if (inject && n == 2) begin
            bus.start = 1'b1;
            bus.md_op = MD_OP_MULTU;
            bus.a     = 32'hFFFF_FFFF;
            bus.b     = 32'hFFFF_FFFF;
            bus.hi_we = 1'b1;
            bus.wd    = 32'hDEAD_BEEF;
         end else begin
            bus.start = 1'b0;
            bus.hi_we = 1'b0;
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      check({tag, "_lat"}, 64'(n), 64'(lat));
      {m_hi, m_lo} = exp[63:0];
      check({tag, "_hi"}, bus.hi, m_hi);
      check({tag, "_lo"}, bus.lo, m_lo);
      bus.rd_sel = 1'b0;
      #1;
      check({tag, "_rd_lo"}, bus.rd_data, m_lo);
      @(posedge clk); #1;
   endtask

   task automatic do_mt(input bit hwe, input bit lwe, input logic [31:0] d);
      bus.hi_we = hwe;
      bus.lo_we = lwe;
      bus.wd    = d;
      @(posedge clk); #1;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      if (hwe) m_hi = d;
      if (lwe) m_lo = d;
   endtask

   initial begin
      int n;
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.md_op  = 3'd0;
      bus.a      = '0;
      bus.b      = '0;
      bus.hi_we  = 1'b0;
      bus.lo_we  = 1'b0;
      bus.wd     = '0;
      bus.rd_sel = 1'b0;
      m_hi = '0;
      m_lo = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      do_op("mult", MD_OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
      check("mult_hi_k", bus.hi, 32'hFFFF_FFFF);
      check("mult_lo_k", bus.lo, 32'hFFFF_FFF1);

      do_op("divu", MD_OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
      check("divu_hi_k", bus.hi, 32'd1);
      check("divu_lo_k", bus.lo, 32'd3);
      do_op("div", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      check("div_hi_k", bus.hi, 32'hFFFF_FFFF);
      check("div_lo_k", bus.lo, 32'hFFFF_FFFD);

      do_mt(1'b1, 1'b0, 32'h0000_0000);
      do_mt(1'b0, 1'b1, 32'h0000_0010);
      check("mtlo", bus.lo, 32'h10);
      do_op("madd", MD_OP_MADD, 32'd3, 32'd4, 1'b0, 1'b0);
      check("madd_hi_k", bus.hi, 32'd0);
      check("madd_lo_k", bus.lo, 32'h1C);
      do_op("msubu", MD_OP_MSUBU, 32'd1, 32'h1D, 1'b0, 1'b0);
      check("msubu_hi_k", bus.hi, 32'hFFFF_FFFF);
      check("msubu_lo_k", bus.lo, 32'hFFFF_FFFF);

      do_mt(1'b1, 1'b0, 32'h1111_1111);
      do_mt(1'b0, 1'b1, 32'h2222_2222);
      do_op("div0", MD_OP_DIV, 32'd1234, 32'd0, 1'b0, 1'b0);
      check("div0_hi_k", bus.hi, 32'h1111_1111);
      check("div0_lo_k", bus.lo, 32'h2222_2222);
      do_op("divmin", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check("divmin_hi_k", bus.hi, 32'd0);
      check("divmin_lo_k", bus.lo, 32'h8000_0000);

      do_op("inject", MD_OP_MULT, 32'd7, 32'd9, 1'b1, 1'b0);
      check("inject_lo_k", bus.lo, 32'd63);
      do_op("startwins", MD_OP_MADD, 32'd2, 32'd3, 1'b0, 1'b1);

      do_mt(1'b1, 1'b1, 32'h5A5A_A5A5);
      check("mtboth_hi", bus.hi, 32'h5A5A_A5A5);
      check("mtboth_lo", bus.lo, 32'h5A5A_A5A5);
      bus.rd_sel = 1'b1;
      #1;
      check("rd_hi", bus.rd_data, m_hi);

      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         case ($urandom_range(0, 9))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) do_mt(1'($urandom), 1'b1, $urandom);
         do_op("rand", rop, ra, rb, 1'b0, 1'b0);
      end

      do_mt(1'b1, 1'b1, 32'h7777_7777);
      bus.start = 1'b1;
      bus.md_op = MD_OP_MULT;
      bus.a     = 32'd100;
      bus.b     = 32'd200;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst3_busy_pre", 64'(bus.busy), 64'd1);
      #1 reset = 1'b1;
      #1;
      check("rst3_busy", 64'(bus.busy), 64'd0);
      check("rst3_hi", bus.hi, 32'd0);
      check("rst3_lo", bus.lo, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      m_hi  = '0;
      m_lo  = '0;
      n = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.busy) n++;
      end
      check("rst3_nobusy", 64'(n), 64'd0);
      check("rst3_hi_after", bus.hi, 32'd0);
      check("rst3_lo_after", bus.lo, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
